// File: rtl/clb_array_cfg_if.sv
// Serial configuration port of one CLB tile. cfg_dout feeds cfg_din of the next
// tile, so a row of tiles loads as one long shift chain.
interface clb_array_cfg_if;
  logic cfg_start;
  logic cfg_en;
  logic cfg_din;
  logic cfg_dout;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;

  modport master (output cfg_start, cfg_en, cfg_din,
                  input  cfg_dout, cfg_busy, cfg_done, cfg_err);
  modport slave  (input  cfg_start, cfg_en, cfg_din,
                  output cfg_dout, cfg_busy, cfg_done, cfg_err);
endinterface

// File: rtl/clb_array_cfg.sv
// Multi-lane CLB tile: per-lane LUT4 + DFF + N/S/E/W routing, loaded through a
// serial shadow chain and committed atomically. Optional frame parity: CLB_CFG_PARITY_EN.

module clb_lane #(
  parameter int CFG_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] frame_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             right_i,
  input  logic             left_i,
  output logic             up_o,
  output logic             down_o,
  output logic             right_o,
  output logic             left_o
);
  // ff_init is only needed at load time, so the active word drops the top bit
  logic [CFG_W-2:0] act_q;
  logic [15:0]      lut;
  logic [3:0]       addr;
  logic             ff_q, ff_en, lut_out, sig;

  // Unknown inputs address the LUT as 0
  assign addr    = {up_i === 1'b1, down_i === 1'b1, right_i === 1'b1, left_i === 1'b1};
  assign lut     = act_q[15:0];
  assign lut_out = lut[4'd15 - addr];
  assign sig     = act_q[18] ? lut_out : ff_q;

  always_comb begin
    ff_en = 1'b0;
    case (act_q[17:16])
      2'b00:   ff_en = left_i;
      2'b01:   ff_en = right_i;
      2'b10:   ff_en = 1'b1;
      default: ff_en = up_i;
    endcase
  end

  assign up_o    = act_q[22] ? sig : down_i;
  assign down_o  = act_q[21] ? sig : up_i;
  assign right_o = act_q[20] ? sig : left_i;
  assign left_o  = act_q[19] ? sig : right_i;

  // Commit load has priority over a normal enabled capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      ff_q  <= 1'b0;
    end else if (load_i) begin
      act_q <= frame_i[CFG_W-2:0];
      ff_q  <= frame_i[CFG_W-1];
    end else if (ff_en) begin
      ff_q  <= lut_out;
    end
  end
endmodule

module clb_array_cfg #(
  parameter int CH    = 1,
  parameter int CFG_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  clb_array_cfg_if.slave cfg,
  input  logic [CH-1:0] up_i,
  input  logic [CH-1:0] down_i,
  input  logic [CH-1:0] right_i,
  input  logic [CH-1:0] left_i,
  output logic [CH-1:0] up_o,
  output logic [CH-1:0] down_o,
  output logic [CH-1:0] right_o,
  output logic [CH-1:0] left_o
);
  localparam int CFG_BITS = CH * CFG_W;
`ifdef CLB_CFG_PARITY_EN
  localparam int FRAME_LEN = CFG_BITS + 1;
`else
  localparam int FRAME_LEN = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic                 err_q, err_d, done_q, done_d;
  logic                 commit, par_ok;
  logic [CFG_BITS-1:0]  frame;

  // In parity mode the trailing bit sits at sh_q[0], below the data frame
  assign frame = sh_q[FRAME_LEN-1 -: CFG_BITS];
`ifdef CLB_CFG_PARITY_EN
  assign par_ok = ~(^sh_q);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    err_d   = err_q;
    done_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_SHIFT: if (cfg.cfg_en) begin
        sh_d  = {sh_q[FRAME_LEN-2:0], cfg.cfg_din};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (par_ok) begin
          commit = 1'b1;
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // A new frame aborts everything, including a pending commit
    if (cfg.cfg_start) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      sh_d    = sh_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cfg.cfg_dout = sh_q[FRAME_LEN-1];
  assign cfg.cfg_busy = (state_q == S_SHIFT);
  assign cfg.cfg_done = done_q;
  assign cfg.cfg_err  = err_q;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    clb_lane #(.CFG_W(CFG_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .frame_i (frame[CFG_W*c +: CFG_W]),
      .load_i  (commit),
      .up_i    (up_i[c]),
      .down_i  (down_i[c]),
      .right_i (right_i[c]),
      .left_i  (left_i[c]),
      .up_o    (up_o[c]),
      .down_o  (down_o[c]),
      .right_o (right_o[c]),
      .left_o  (left_o[c])
    );
  end
endmodule

// File: tb/tb_clb_array_cfg.sv
// Bench for clb_array_cfg with two lanes: routing tables, FF latency/hold,
// aborted loads, reset mid-load and (when enabled) frame parity.
module tb_clb_array_cfg;
  localparam int CH = 2, CFG_W = 24, CFG_BITS = CH * CFG_W;

  // lane1 word, lane0 word
  localparam logic [CFG_BITS-1:0] F_AND  = {24'h000000, 24'h7C0001};
  localparam logic [CFG_BITS-1:0] F_FF   = {24'h7AFFFF, 24'h7C0001};
  localparam logic [CFG_BITS-1:0] F_HOLD = {24'hF80000, 24'h7C0001};

  logic clk = 1'b0;
  logic rst_n;
  logic [CH-1:0] up_i, down_i, right_i, left_i;
  logic [CH-1:0] up_o, down_o, right_o, left_o;

  clb_array_cfg_if cfg();

  clb_array_cfg #(.CH(CH), .CFG_W(CFG_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg),
    .up_i(up_i), .down_i(down_i), .right_i(right_i), .left_i(left_i),
    .up_o(up_o), .down_o(down_o), .right_o(right_o), .left_o(left_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] u, d, r, l;
    logic [7:0] exp;
  } vec_t;
  typedef struct {
    string      nm;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[12];
  sb_t  sbq[$];
  int   total = 0, bad = 0;
  int   mon_bad = 0;
  bit   mon_en = 0;
  logic [7:0] mon_exp = 8'h00;

  function automatic logic [7:0] outs();
    return {up_o, down_o, right_o, left_o};
  endfunction

  // Expected outputs with lane1 passing through; lane0 either passes or drives a
  function automatic vec_t mk(logic [1:0] u, d, r, l, bit pass0, logic a);
    vec_t v;
    v.u = u; v.d = d; v.r = r; v.l = l;
    v.exp = {d, u, l, r};
    if (!pass0) begin
      v.exp[6] = a; v.exp[4] = a; v.exp[2] = a; v.exp[0] = a;
    end
    return v;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] u, d, r, l);
    up_i = u; down_i = d; right_i = r; left_i = l;
  endtask

  task automatic run_table(input int lo, input int hi, input string tag);
    sb_t s;
    for (int i = lo; i <= hi; i++) begin
      set_in(tbl[i].u, tbl[i].d, tbl[i].r, tbl[i].l);
      sbq.push_back('{$sformatf("%s[%0d]", tag, i), tbl[i].exp});
      #1;
      s = sbq.pop_front();
      chk8(s.nm, outs(), s.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start with cfg_en/din also high: that bit must not be shifted
  task automatic start_frame();
    cfg.cfg_start = 1'b1; cfg.cfg_en = 1'b1; cfg.cfg_din = 1'b1;
    tick();
    cfg.cfg_start = 1'b0; cfg.cfg_en = 1'b0;
  endtask

  task automatic shift_bits(input logic [CFG_BITS-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      cfg.cfg_en = 1'b1;
      cfg.cfg_din = f[CFG_BITS-1-i];
      tick();
      if (mon_en && (outs() !== mon_exp || cfg.cfg_done !== 1'b0)) mon_bad++;
    end
    cfg.cfg_en = 1'b0;
  endtask

`ifdef CLB_CFG_PARITY_EN
  task automatic shift_parity(input logic [CFG_BITS-1:0] f, input bit bad_p);
    cfg.cfg_en = 1'b1;
    cfg.cfg_din = (^f) ^ bad_p;
    tick();
    cfg.cfg_en = 1'b0;
  endtask
`endif

  // Returns in the COMMIT cycle
  task automatic send_frame(input logic [CFG_BITS-1:0] f);
    start_frame();
    shift_bits(f, CFG_BITS);
`ifdef CLB_CFG_PARITY_EN
    shift_parity(f, 1'b0);
`endif
  endtask

  initial begin
    int dcnt;
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 1, 1'b0);
    tbl[1]  = mk(2'b00, 2'b00, 2'b00, 2'b10, 1, 1'b0);
    tbl[2]  = mk(2'b10, 2'b01, 2'b11, 2'b00, 1, 1'b0);
    tbl[3]  = mk(2'b11, 2'b11, 2'b11, 2'b11, 1, 1'b0);
    tbl[4]  = mk(2'b11, 2'b01, 2'b01, 2'b11, 0, 1'b1);
    tbl[5]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 0, 1'b1);
    tbl[6]  = mk(2'b00, 2'b01, 2'b01, 2'b01, 0, 1'b0);
    tbl[7]  = mk(2'b01, 2'b00, 2'b01, 2'b01, 0, 1'b0);
    tbl[8]  = mk(2'b01, 2'b01, 2'b00, 2'b01, 0, 1'b0);
    tbl[9]  = mk(2'b01, 2'b01, 2'b01, 2'b00, 0, 1'b0);
    tbl[10] = mk(2'b10, 2'b10, 2'b10, 2'b10, 0, 1'b0);
    tbl[11] = mk(2'b11, 2'b11, 2'b11, 2'b11, 0, 1'b1);

    rst_n = 1'b0;
    cfg.cfg_start = 1'b0; cfg.cfg_en = 1'b0; cfg.cfg_din = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk1("rst_busy", cfg.cfg_busy, 1'b0);
    chk1("rst_done", cfg.cfg_done, 1'b0);
    chk1("rst_err",  cfg.cfg_err,  1'b0);
    chk1("rst_dout", cfg.cfg_dout, 1'b0);
    run_table(0, 3, "pass");

    // LUT AND on lane0
    send_frame(F_AND);
    chk1("and_commit_busy", cfg.cfg_busy, 1'b0);
    chk1("and_dout", cfg.cfg_dout, 1'b0);
    tick();
    chk1("and_done", cfg.cfg_done, 1'b1);
    tick();
    chk1("and_done_pulse", cfg.cfg_done, 1'b0);
    run_table(4, 11, "and");

    // Lane1 FF always enabled; second pass checks commit beats capture
    set_in(2'b01, 2'b11, 2'b01, 2'b01);
    for (int k = 0; k < 2; k++) begin
      send_frame(F_FF);
      chk1($sformatf("ff%0d_commit_cycle", k), up_o[1], 1'b1);
      tick();
      chk1($sformatf("ff%0d_done", k), cfg.cfg_done, 1'b1);
      chk1($sformatf("ff%0d_init", k), up_o[1], 1'b0);
      tick();
      chk1($sformatf("ff%0d_capture", k), up_o[1], 1'b1);
    end

    // Lane1 FF enabled by left_i[1]; init 1, LUT 0
    send_frame(F_HOLD);
    chk1("hold_dout", cfg.cfg_dout, 1'b1);
    tick();
    chk1("hold_init", up_o[1], 1'b1);
    tick(); tick(); tick();
    chk1("hold_held", up_o[1], 1'b1);
    left_i = 2'b11;
    #1;
    chk1("hold_no_comb", up_o[1], 1'b1);
    tick();
    chk1("hold_capture", up_o[1], 1'b0);
    left_i = 2'b01;

    // Aborted load then full reload; active plane must not move meanwhile
    set_in(2'b11, 2'b01, 2'b01, 2'b01);
    tick();
    chk8("mid_before", outs(), 8'h55);
    mon_exp = 8'h55; mon_bad = 0; mon_en = 1;
    start_frame();
    shift_bits(F_FF, 20);
    chk1("mid_busy", cfg.cfg_busy, 1'b1);
    send_frame(F_AND);
    mon_en = 0;
    chk8("mid_stable", 8'(mon_bad), 8'd0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cfg.cfg_done === 1'b1) dcnt++;
    end
    chk8("mid_done_once", 8'(dcnt), 8'd1);
    chk8("mid_after", outs(), 8'h75);

    // Reset while shifting
    set_in(2'b10, 2'b01, 2'b11, 2'b11);
    #1;
    chk8("rs_before", outs(), 8'h2A);
    start_frame();
    shift_bits(F_HOLD, 10);
    rst_n = 1'b0;
    #1;
    chk1("rs_busy", cfg.cfg_busy, 1'b0);
    chk8("rs_pass", outs(), 8'h6F);
    chk1("rs_dout", cfg.cfg_dout, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CLB_CFG_PARITY_EN
    start_frame();
    shift_bits(F_AND, CFG_BITS);
    shift_parity(F_AND, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cfg.cfg_done === 1'b1) dcnt++;
    end
    chk8("par_no_done", 8'(dcnt), 8'd0);
    chk1("par_err", cfg.cfg_err, 1'b1);
    chk8("par_unchanged", outs(), 8'h6F);
`endif

    send_frame(F_AND);
    tick();
    chk1("fin_done", cfg.cfg_done, 1'b1);
    chk1("fin_err", cfg.cfg_err, 1'b0);
    chk8("fin_outs", outs(), 8'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
